// File: rtl/ps2_pkg.sv
// Shared types and helpers for the PS/2 device-side transmitter.
package ps2_pkg;

    localparam int PS2_FRAME_BITS = 11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_POP,
        ST_BIT_HI,
        ST_BIT_LO,
        ST_STOP_HI,
        ST_GAP
    } ps2_state_e;

    // Parity bit that makes the count of ones in data plus parity odd.
    function automatic logic odd_parity(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/ps2_tx_fifo.sv
// Synchronous byte FIFO with peekable head; DEPTH must be a power of two >= 2.
module ps2_tx_fifo #(
    parameter int DEPTH = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  logic [7:0] data_i,
    output logic [7:0] head_o,
    output logic       full_o,
    output logic       empty_o
);
    localparam int AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q;
    logic [AW-1:0] rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok;
    logic          pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;
    assign full_o  = (count_q == (AW+1)'(DEPTH));
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/ps2_device_tx.sv
// PS/2 device-side transmitter: buffers bytes and sends 11-bit frames on ps2_clk/ps2_dat.
// Optional host-inhibit support (ps2_clk_in, abort and retransmit) is enabled by PS2_INHIBIT_EN.
module ps2_device_tx
    import ps2_pkg::*;
#(
    parameter int CLK_DIV    = 2500,
    parameter int GAP_CYCLES = 5000,
    parameter int FIFO_DEPTH = 8
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [7:0] in_byte,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       ps2_clk,
    output logic       ps2_dat,
    output logic       busy,
    output logic       tx_done
`ifdef PS2_INHIBIT_EN
    ,
    input  logic       ps2_clk_in
`endif
);
    localparam int HALF_W = $clog2(CLK_DIV);
    localparam int GAP_W  = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(GAP_CYCLES - 1);
    localparam logic [3:0]        LAST_BIT  = 4'(PS2_FRAME_BITS - 1);

    ps2_state_e  state_q, state_d;
    logic [10:0] shift_q, shift_d;
    logic [3:0]  bit_cnt_q, bit_cnt_d;
    logic [HALF_W-1:0] half_cnt_q, half_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;
    logic ps2_clk_q, ps2_clk_d;
    logic ps2_dat_q, ps2_dat_d;
    logic tx_done_q, tx_done_d;

    logic       fifo_pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic [7:0] fifo_head;
    logic       host_inhibit;
    logic       pop_at_done;

`ifdef PS2_INHIBIT_EN
    // The head stays in the FIFO until the frame completes so an aborted frame can be resent.
    assign host_inhibit = ~ps2_clk_in;
    assign pop_at_done  = 1'b1;
`else
    assign host_inhibit = 1'b0;
    assign pop_at_done  = 1'b0;
`endif

    ps2_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk_i   (CLOCK_50),
        .reset_i (reset),
        .push_i  (in_valid),
        .pop_i   (fifo_pop),
        .data_i  (in_byte),
        .head_o  (fifo_head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign in_ready = ~fifo_full;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;
    assign ps2_clk  = ps2_clk_q;
    assign ps2_dat  = ps2_dat_q;
    assign tx_done  = tx_done_q;

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            shift_q    <= '1;
            bit_cnt_q  <= '0;
            half_cnt_q <= '0;
            gap_cnt_q  <= '0;
            ps2_clk_q  <= 1'b1;
            ps2_dat_q  <= 1'b1;
            tx_done_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bit_cnt_q  <= bit_cnt_d;
            half_cnt_q <= half_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            ps2_clk_q  <= ps2_clk_d;
            ps2_dat_q  <= ps2_dat_d;
            tx_done_q  <= tx_done_d;
        end
    end

    // Data follows the shift register one cycle into BIT_HI, so it never moves with a clock edge.
    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bit_cnt_d  = bit_cnt_q;
        half_cnt_d = half_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        ps2_clk_d  = ps2_clk_q;
        ps2_dat_d  = ps2_dat_q;
        tx_done_d  = 1'b0;
        fifo_pop   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty && !host_inhibit) state_d = ST_POP;
            end
            ST_POP: begin
                shift_d    = {1'b1, odd_parity(fifo_head), fifo_head, 1'b0};
                bit_cnt_d  = '0;
                half_cnt_d = '0;
                ps2_clk_d  = 1'b1;
                ps2_dat_d  = 1'b0;
                fifo_pop   = !pop_at_done;
                state_d    = ST_BIT_HI;
            end
            ST_BIT_HI: begin
                ps2_dat_d = shift_q[0];
                if (host_inhibit && bit_cnt_q < LAST_BIT) begin
                    ps2_dat_d  = 1'b1;
                    ps2_clk_d  = 1'b1;
                    gap_cnt_d  = '0;
                    half_cnt_d = '0;
                    state_d    = ST_GAP;
                end else if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    ps2_clk_d  = 1'b0;
                    state_d    = ST_BIT_LO;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            ST_BIT_LO: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    ps2_clk_d  = 1'b1;
                    if (bit_cnt_q < LAST_BIT) begin
                        shift_d   = {1'b1, shift_q[10:1]};
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        state_d   = ST_BIT_HI;
                    end else begin
                        state_d   = ST_STOP_HI;
                    end
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            ST_STOP_HI: begin
                if (half_cnt_q == HALF_LAST) begin
                    half_cnt_d = '0;
                    tx_done_d  = 1'b1;
                    fifo_pop   = pop_at_done;
                    gap_cnt_d  = '0;
                    state_d    = ST_GAP;
                end else begin
                    half_cnt_d = half_cnt_q + HALF_W'(1);
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    state_d = ST_IDLE;
                end else begin
                    gap_cnt_d = gap_cnt_q + GAP_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ps2_device_tx.sv
// Self-checking bench for ps2_device_tx; a line monitor decodes frames and checks them against a queue.
module tb_ps2_device_tx;
    localparam int CLK_DIV    = 4;
    localparam int GAP_CYCLES = 8;
    localparam int FIFO_DEPTH = 8;
`ifdef PS2_INHIBIT_EN
    localparam int ACCEPTS_TO_FULL = 8;
`else
    localparam int ACCEPTS_TO_FULL = 9;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [7:0] in_byte  = 8'h00;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic       ps2_clk;
    logic       ps2_dat;
    logic       busy;
    logic       tx_done;
`ifdef PS2_INHIBIT_EN
    logic       ps2_clk_in = 1'b1;
`endif

    int checks = 0;
    int errors = 0;
    logic [10:0] expQ[$];

    int cyc = 0;
    int lastFallCyc = 0;
    int bitIdx = 0;
    int clkHighRun = 0;
    int highRun = 1000;
    int gapRun = 1000;
    int txDoneCount = 0;
    int abortCount = 0;
    logic prevClk = 1'b1;
    logic prevDat = 1'b1;
    logic [10:0] acc = '0;
    logic [10:0] lastFrame = '0;
    logic [10:0] expFrame;

    ps2_device_tx #(
        .CLK_DIV    (CLK_DIV),
        .GAP_CYCLES (GAP_CYCLES),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLOCK_50 (CLOCK_50),
        .reset    (reset),
        .in_byte  (in_byte),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .ps2_clk  (ps2_clk),
        .ps2_dat  (ps2_dat),
        .busy     (busy),
        .tx_done  (tx_done)
`ifdef PS2_INHIBIT_EN
        ,
        .ps2_clk_in (ps2_clk_in)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    function automatic logic [10:0] frameOf(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return {1'b1, (ones % 2 == 0), b, 1'b0};
    endfunction

    // Line monitor: samples on the falling system clock, decodes frames and scores them.
    initial begin
        forever begin
            @(negedge CLOCK_50);
            cyc++;
            if (reset) begin
                bitIdx = 0;
                clkHighRun = 0;
            end else begin
                if (ps2_dat !== prevDat) begin
                    checks++;
                    if (!(prevClk === 1'b1 && ps2_clk === 1'b1)) begin
                        errors++;
                        $display("[TB] FAIL dat_stable: ps2_dat moved with ps2_clk %b->%b, required 1->1", prevClk, ps2_clk);
                    end
                end
                if (ps2_clk === 1'b1 && ps2_dat === 1'b1) highRun++;
                else begin
                    if (highRun != 0) gapRun = highRun;
                    highRun = 0;
                end
                if (ps2_clk === 1'b1) clkHighRun++;
                else clkHighRun = 0;
                if (bitIdx != 0 && clkHighRun > 3 * CLK_DIV) begin
                    abortCount++;
                    bitIdx = 0;
                end
                if (prevClk === 1'b1 && ps2_clk === 1'b0) begin
                    checks++;
                    if (bitIdx == 0) begin
                        if (gapRun < GAP_CYCLES) begin
                            errors++;
                            $display("[TB] FAIL frame_gap: idle run %0d cycles, required >= %0d", gapRun, GAP_CYCLES);
                        end
                    end else if (cyc - lastFallCyc != 2 * CLK_DIV) begin
                        errors++;
                        $display("[TB] FAIL bit_period: %0d cycles between falls, required %0d", cyc - lastFallCyc, 2 * CLK_DIV);
                    end
                    acc[bitIdx] = ps2_dat;
                    bitIdx++;
                    lastFallCyc = cyc;
                    if (bitIdx == 11) begin
                        checks++;
                        if (expQ.size() == 0) begin
                            errors++;
                            $display("[TB] FAIL unexpected_frame: got %h, required no frame", acc);
                        end else begin
                            expFrame = expQ.pop_front();
                            if (acc !== expFrame) begin
                                errors++;
                                $display("[TB] FAIL frame_bits: got %h, required %h", acc, expFrame);
                            end
                        end
                        lastFrame = acc;
                        bitIdx = 0;
                    end
                end
            end
            prevClk = ps2_clk;
            prevDat = ps2_dat;
            if (tx_done === 1'b1) txDoneCount++;
        end
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: time limit reached, required run to complete");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic sendByte(input logic [7:0] b);
        int guard = 0;
        @(negedge CLOCK_50);
        while (in_ready !== 1'b1 && guard < 2000) begin
            @(negedge CLOCK_50);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("[TB] FAIL send_ready: in_ready %b, required 1", in_ready);
        end
        in_byte  = b;
        in_valid = 1'b1;
        expQ.push_back(frameOf(b));
        @(negedge CLOCK_50);
        in_valid = 1'b0;
    endtask

    task automatic waitIdle(input int budget);
        int n = 0;
        while (busy !== 1'b0 && n < budget) begin
            @(negedge CLOCK_50);
            n++;
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_timeout: busy %b after %0d cycles, required 0", busy, budget);
        end
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("[TB] FAIL scoreboard_left: %0d frames outstanding, required 0", expQ.size());
            expQ.delete();
        end
    endtask

    task automatic test_reset();
        repeat (50) @(negedge CLOCK_50);
        checks++;
        if (ps2_clk !== 1'b1) begin errors++; $display("[TB] FAIL reset_clk: got %b, required 1", ps2_clk); end
        checks++;
        if (ps2_dat !== 1'b1) begin errors++; $display("[TB] FAIL reset_dat: got %b, required 1", ps2_dat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b, required 0", busy); end
        checks++;
        if (in_ready !== 1'b1) begin errors++; $display("[TB] FAIL reset_ready: got %b, required 1", in_ready); end
        checks++;
        if (tx_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b, required 0", tx_done); end
    endtask

    task automatic test_single_frame();
        int done0;
        done0 = txDoneCount;
        sendByte(8'h1C);
        @(negedge CLOCK_50);
        checks++;
        if (ps2_dat !== 1'b1) begin errors++; $display("[TB] FAIL latency_early: ps2_dat %b one edge after accept, required 1", ps2_dat); end
        @(negedge CLOCK_50);
        checks++;
        if (ps2_dat !== 1'b0) begin errors++; $display("[TB] FAIL latency_start: ps2_dat %b two edges after accept, required 0", ps2_dat); end
        repeat (3) @(negedge CLOCK_50);
        checks++;
        if (ps2_clk !== 1'b1) begin errors++; $display("[TB] FAIL first_fall_early: ps2_clk %b, required 1", ps2_clk); end
        @(negedge CLOCK_50);
        checks++;
        if (ps2_clk !== 1'b0) begin errors++; $display("[TB] FAIL first_fall: ps2_clk %b, required 0", ps2_clk); end
        waitIdle(1000);
        checks++;
        if (txDoneCount - done0 != 1) begin errors++; $display("[TB] FAIL single_done: %0d pulses, required 1", txDoneCount - done0); end
        checks++;
        if (lastFrame !== 11'h438) begin errors++; $display("[TB] FAIL single_bits: got %h, required 438", lastFrame); end
    endtask

    task automatic test_back_to_back();
        int done0;
        done0 = txDoneCount;
        sendByte(8'h00);
        sendByte(8'hFF);
        waitIdle(2000);
        checks++;
        if (txDoneCount - done0 != 2) begin errors++; $display("[TB] FAIL b2b_done: %0d pulses, required 2", txDoneCount - done0); end
        checks++;
        if (lastFrame !== 11'h7FE) begin errors++; $display("[TB] FAIL b2b_last: got %h, required 7fe", lastFrame); end
    endtask

    task automatic test_fifo_full();
        int done0;
        int accepted = 0;
        int stalls = 0;
        int guard = 0;
        logic readyNow;
        done0 = txDoneCount;
        @(negedge CLOCK_50);
        in_valid = 1'b1;
        in_byte  = 8'h01;
        while (accepted < 9 && guard < 3000) begin
            readyNow = in_ready;
            @(negedge CLOCK_50);
            guard++;
            if (readyNow === 1'b1) begin
                expQ.push_back(frameOf(in_byte));
                accepted++;
                in_byte = 8'(accepted + 1);
                if (accepted == ACCEPTS_TO_FULL) begin
                    checks++;
                    if (in_ready !== 1'b0) begin errors++; $display("[TB] FAIL fifo_full_ready: got %b after %0d accepts, required 0", in_ready, accepted); end
                end
            end else if (accepted < ACCEPTS_TO_FULL) begin
                stalls++;
            end
        end
        in_valid = 1'b0;
        checks++;
        if (accepted != 9) begin errors++; $display("[TB] FAIL fifo_accepts: got %0d, required 9", accepted); end
        checks++;
        if (stalls != 0) begin errors++; $display("[TB] FAIL fifo_stalls: got %0d before full, required 0", stalls); end
        waitIdle(5000);
        checks++;
        if (txDoneCount - done0 != 9) begin errors++; $display("[TB] FAIL fifo_done: %0d pulses, required 9", txDoneCount - done0); end
    endtask

    task automatic test_reset_mid_frame();
        int done0;
        int guard = 0;
        done0 = txDoneCount;
        sendByte(8'h5A);
        while (bitIdx != 6 && guard < 500) begin
            @(negedge CLOCK_50);
            guard++;
        end
        checks++;
        if (bitIdx != 6) begin errors++; $display("[TB] FAIL midframe_wait: bit index %0d, required 6", bitIdx); end
        reset = 1'b1;
        @(negedge CLOCK_50);
        checks++;
        if (ps2_clk !== 1'b1) begin errors++; $display("[TB] FAIL midreset_clk: got %b, required 1", ps2_clk); end
        checks++;
        if (ps2_dat !== 1'b1) begin errors++; $display("[TB] FAIL midreset_dat: got %b, required 1", ps2_dat); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("[TB] FAIL midreset_busy: got %b, required 0", busy); end
        @(negedge CLOCK_50);
        reset = 1'b0;
        expQ.delete();
        repeat (20) @(negedge CLOCK_50);
        checks++;
        if (txDoneCount != done0) begin errors++; $display("[TB] FAIL midreset_done: %0d pulses, required 0", txDoneCount - done0); end
        sendByte(8'h5A);
        waitIdle(1000);
        checks++;
        if (txDoneCount - done0 != 1) begin errors++; $display("[TB] FAIL resend_done: %0d pulses, required 1", txDoneCount - done0); end
        checks++;
        if (lastFrame !== 11'h6B4) begin errors++; $display("[TB] FAIL resend_bits: got %h, required 6b4", lastFrame); end
    endtask

`ifdef PS2_INHIBIT_EN
    task automatic test_inhibit();
        int done0;
        int abort0;
        int guard = 0;
        done0  = txDoneCount;
        abort0 = abortCount;
        sendByte(8'h29);
        while (bitIdx != 3 && guard < 500) begin
            @(negedge CLOCK_50);
            guard++;
        end
        while (ps2_clk !== 1'b1 && guard < 500) begin
            @(negedge CLOCK_50);
            guard++;
        end
        checks++;
        if (bitIdx != 3) begin errors++; $display("[TB] FAIL inhibit_wait: bit index %0d, required 3", bitIdx); end
        ps2_clk_in = 1'b0;
        repeat (30) @(negedge CLOCK_50);
        checks++;
        if (ps2_clk !== 1'b1 || ps2_dat !== 1'b1) begin
            errors++;
            $display("[TB] FAIL inhibit_lines: clk %b dat %b, required 1 1", ps2_clk, ps2_dat);
        end
        checks++;
        if (busy !== 1'b1) begin errors++; $display("[TB] FAIL inhibit_busy: got %b, required 1", busy); end
        ps2_clk_in = 1'b1;
        waitIdle(2000);
        checks++;
        if (txDoneCount - done0 != 1) begin errors++; $display("[TB] FAIL inhibit_done: %0d pulses, required 1", txDoneCount - done0); end
        checks++;
        if (abortCount - abort0 != 1) begin errors++; $display("[TB] FAIL inhibit_abort: %0d aborts, required 1", abortCount - abort0); end
        checks++;
        if (lastFrame !== 11'h452) begin errors++; $display("[TB] FAIL inhibit_bits: got %h, required 452", lastFrame); end
    endtask
`endif

    initial begin
        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
`ifdef PS2_INHIBIT_EN
        test_inhibit();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
